// File: rtl/axis_rx_frame_checker.sv
// -----------------------------------------------------------------------------
// axis_rx_frame_checker
//
// Receive-side checker for the 10G Ethernet loopback test path. The MAC RX
// AXI-Stream carries no backpressure, so every valid beat is consumed as it
// arrives. Each beat is compared against the fixed frame the TX traffic
// generator emits:
//   beat 0    : destination MAC + upper half of source MAC
//   beat 1    : lower source MAC, EtherType, 16'hFFFF
//   beat n>=2 : the 16-bit value (n-1) repeated four times
// The checker also checks the frame length, tkeep on every beat, and tuser on
// the tlast beat. For each frame it gives a one-cycle verdict, and it keeps
// saturating good/bad frame counters and sticky error flags.
//
// Ports
//   i_clk             : MAC RX user clock
//   i_rst             : synchronous reset, active high
//   i_stat_rx_status  : MAC link / block-lock status
//   i_clr_stats       : pulse, clears counters and sticky flags
//   s_axis_rx_tvalid  : beat valid (no tready)
//   s_axis_rx_tdata   : beat data, first wire byte in [7:0]
//   s_axis_rx_tlast   : last beat of frame
//   s_axis_rx_tkeep   : byte enables
//   s_axis_rx_tuser   : MAC bad-frame flag, meaningful on tlast
//   o_link_ready      : checker armed after a stable link
//   o_frame_done      : one-cycle verdict strobe
//   o_frame_good      : verdict, valid with o_frame_done
//   o_good_cnt        : saturating good-frame counter
//   o_bad_cnt         : saturating bad-frame counter
//   o_err_flags       : sticky {tuser, tkeep, length, payload, header}
// -----------------------------------------------------------------------------
module axis_rx_frame_checker #(
  parameter int unsigned P_FRAME_LEN = 186,
  parameter logic [47:0] P_DST_MAC   = 48'hff_ff_ff_ff_ff_ff,
  parameter logic [47:0] P_SRC_MAC   = 48'h01_02_03_04_05_06,
  parameter logic [15:0] P_TYPE      = 16'h0800,
  parameter int unsigned P_LINK_WAIT = 63
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stat_rx_status,
  input  logic        i_clr_stats,
  input  logic        s_axis_rx_tvalid,
  input  logic [63:0] s_axis_rx_tdata,
  input  logic        s_axis_rx_tlast,
  input  logic [7:0]  s_axis_rx_tkeep,
  input  logic        s_axis_rx_tuser,
  output logic        o_link_ready,
  output logic        o_frame_done,
  output logic        o_frame_good,
  output logic [31:0] o_good_cnt,
  output logic [31:0] o_bad_cnt,
  output logic [4:0]  o_err_flags
);

  // Index of the beat that must carry tlast, and the first index that is
  // already past the end of a legal frame.
  localparam logic [15:0] LAST_IDX  = 16'(P_FRAME_LEN - 1);
  localparam logic [15:0] LEN_IDX   = 16'(P_FRAME_LEN);
  localparam logic [5:0]  LINK_LAST = 6'(P_LINK_WAIT - 1);

  // Bit positions inside the per-frame and sticky error vectors
  localparam int ERR_HDR  = 0;
  localparam int ERR_PAY  = 1;
  localparam int ERR_LEN  = 2;
  localparam int ERR_KEEP = 3;
  localparam int ERR_USER = 4;

  typedef enum logic [1:0] {
    S_LINK,
    S_IDLE,
    S_FRAME
  } state_t;

  state_t      state;
  logic [5:0]  link_cnt;
  logic [15:0] beat_cnt;
  logic [4:0]  frame_err;

  logic [63:0] rx_word;
  logic [63:0] exp_word;
  logic [15:0] cur_idx;
  logic [15:0] payload_val;
  logic        is_hdr;
  logic        word_bad;
  logic [4:0]  beat_err;
  logic [4:0]  frame_err_next;
  logic        checking;
  logic        verdict;

  // The expected pattern is written in wire order (first byte in the MSB).
  // The MAC puts the first byte in the LSB, so the beat is byte-reversed
  // before it is compared.
  always_comb begin
    rx_word = '0;
    for (int k = 0; k < 8; k++) begin
      rx_word[63-8*k -: 8] = s_axis_rx_tdata[8*k +: 8];
    end
  end

  // Build the expected word for the beat being received now. In S_IDLE the
  // next valid beat is always beat 0 of a new frame. Past the nominal length
  // the incrementing payload is still expected to continue.
  always_comb begin
    cur_idx     = (state == S_FRAME) ? beat_cnt : 16'd0;
    payload_val = cur_idx - 16'd1;
    if (cur_idx == 16'd0) begin
      exp_word = {P_DST_MAC, P_SRC_MAC[47:32]};
    end else if (cur_idx == 16'd1) begin
      exp_word = {P_SRC_MAC[31:0], P_TYPE, 16'hFFFF};
    end else begin
      exp_word = {4{payload_val}};
    end
  end

  // Per-beat error bits. A data mismatch counts as a header error or a
  // payload error, depending on which beat it is on. A length error is
  // raised either by tlast at the wrong index or by running past the end
  // without tlast.
  always_comb begin
    is_hdr   = (cur_idx < 16'd2);
    word_bad = (rx_word != exp_word);
    beat_err = '0;
    beat_err[ERR_HDR]  = is_hdr && word_bad;
    beat_err[ERR_PAY]  = !is_hdr && word_bad;
    beat_err[ERR_LEN]  = s_axis_rx_tlast ? (cur_idx != LAST_IDX)
                                         : (cur_idx >= LEN_IDX);
    beat_err[ERR_KEEP] = (s_axis_rx_tkeep != 8'hFF);
    beat_err[ERR_USER] = s_axis_rx_tlast && s_axis_rx_tuser;
  end

  // A beat only counts while the checker is armed and the link is still up.
  // A frame that starts in S_IDLE starts with a clean error accumulator.
  always_comb begin
    checking       = ((state == S_IDLE) || (state == S_FRAME)) &&
                     i_stat_rx_status && s_axis_rx_tvalid;
    frame_err_next = ((state == S_FRAME) ? frame_err : 5'b0) | beat_err;
    verdict        = checking && s_axis_rx_tlast;
  end

  // Main FSM. It waits for a stable link, then follows frame boundaries and
  // issues the registered verdict strobe. If the link drops in any state,
  // the checker disarms and the in-flight frame is dropped without a verdict.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_LINK;
      link_cnt     <= '0;
      beat_cnt     <= '0;
      frame_err    <= '0;
      o_link_ready <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_good <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      o_frame_good <= 1'b0;
      if (!i_stat_rx_status) begin
        state        <= S_LINK;
        link_cnt     <= '0;
        beat_cnt     <= '0;
        frame_err    <= '0;
        o_link_ready <= 1'b0;
      end else begin
        case (state)
          S_LINK: begin
            link_cnt <= link_cnt + 6'd1;
            if (link_cnt == LINK_LAST) begin
              state        <= S_IDLE;
              o_link_ready <= 1'b1;
            end
          end

          S_IDLE: begin
            if (s_axis_rx_tvalid) begin
              if (s_axis_rx_tlast) begin
                o_frame_done <= 1'b1;
                o_frame_good <= ~|frame_err_next;
                frame_err    <= '0;
                beat_cnt     <= '0;
              end else begin
                state     <= S_FRAME;
                beat_cnt  <= 16'd1;
                frame_err <= frame_err_next;
              end
            end
          end

          S_FRAME: begin
            if (s_axis_rx_tvalid) begin
              if (s_axis_rx_tlast) begin
                o_frame_done <= 1'b1;
                o_frame_good <= ~|frame_err_next;
                state        <= S_IDLE;
                beat_cnt     <= '0;
                frame_err    <= '0;
              end else begin
                if (beat_cnt != 16'hFFFF) begin
                  beat_cnt <= beat_cnt + 16'd1;
                end
                frame_err <= frame_err_next;
              end
            end
          end

          default: begin
            state <= S_LINK;
          end
        endcase
      end
    end
  end

  // Statistics. They update on the same edge that raises o_frame_done, so
  // the counters and the verdict strobe line up. A clear request overrides a
  // coincident verdict update.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_good_cnt  <= '0;
      o_bad_cnt   <= '0;
      o_err_flags <= '0;
    end else if (i_clr_stats) begin
      o_good_cnt  <= '0;
      o_bad_cnt   <= '0;
      o_err_flags <= '0;
    end else if (verdict) begin
      if (frame_err_next == 5'b0) begin
        if (o_good_cnt != 32'hFFFF_FFFF) begin
          o_good_cnt <= o_good_cnt + 32'd1;
        end
      end else begin
        if (o_bad_cnt != 32'hFFFF_FFFF) begin
          o_bad_cnt <= o_bad_cnt + 32'd1;
        end
      end
      o_err_flags <= o_err_flags | frame_err_next;
    end
  end

endmodule
